// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Brief    : Program counter with a call/return stack, a sticky halt state and
//            a fetch/operand address mux. The optional breakpoint logic is
//            enabled by defining PC_BRKPT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter int ADDR_W      = 5,
    parameter int OPC_W       = 3,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              step,
    input  logic              fetch_sel,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [OPC_W-1:0]  opcode,
    input  logic              skz_cmp,
    input  logic              load_in,
    input  logic              call_in,
    input  logic              ret_in,
`ifdef PC_BRKPT_EN
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    output logic              bp_hit,
`endif
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] address_out,
    output logic              halted,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    localparam logic [OPC_W-1:0] c_op_hlt = OPC_W'(0);
    localparam logic [OPC_W-1:0] c_op_skz = OPC_W'(1);
    localparam logic [OPC_W-1:0] c_op_jmp = OPC_W'(7);

    localparam logic [SP_W-1:0]  c_sp_full = SP_W'(STACK_DEPTH);

    localparam logic [0:0] c_s_run  = 1'b0;
    localparam logic [0:0] c_s_halt = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [SP_W-1:0]   r_sp;
    logic              r_err;
    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [SP_W-1:0]   w_sp_nxt;
    logic              w_err_nxt;
    logic              w_push;
    logic              w_update;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_inc2;
    logic [ADDR_W-1:0] w_top;
    logic              w_full;
    logic              w_empty;

`ifdef PC_BRKPT_EN
    logic              r_bp_hit;
    logic              w_bp_nxt;
`endif

    assign w_pc_inc  = r_pc + ADDR_W'(1);
    assign w_pc_inc2 = r_pc + ADDR_W'(2);
    assign w_full    = (r_sp == c_sp_full);
    assign w_empty   = (r_sp == '0);

    // Top of stack is the entry just below the stack pointer.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (r_sp == SP_W'(i + 1)) begin
                w_top = r_stack[i];
            end
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_s_run;
            r_pc    <= '0;
            r_sp    <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
`ifdef PC_BRKPT_EN
            r_bp_hit <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_sp    <= w_sp_nxt;
            r_err   <= w_err_nxt;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (w_push && (r_sp == SP_W'(i))) begin
                    r_stack[i] <= w_pc_inc;
                end
            end
`ifdef PC_BRKPT_EN
            r_bp_hit <= w_bp_nxt;
`endif
        end
    end

    // Next-state logic: one prioritised action per committed step
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_sp_nxt    = r_sp;
        w_err_nxt   = r_err;
        w_push      = 1'b0;
        w_update    = 1'b0;
`ifdef PC_BRKPT_EN
        w_bp_nxt    = 1'b0;
`endif
        if (en && step) begin
            if (load_in) begin
                w_pc_nxt    = addr_in;
                w_state_nxt = c_s_run;
                w_update    = 1'b1;
            end else if (r_state == c_s_run) begin
                w_update = 1'b1;
                if (call_in) begin
                    if (!w_full) begin
                        w_push   = 1'b1;
                        w_sp_nxt = r_sp + SP_W'(1);
                        w_pc_nxt = addr_in;
                    end else begin
                        w_err_nxt = 1'b1;
                        w_pc_nxt  = w_pc_inc;
                    end
                end else if (ret_in) begin
                    if (!w_empty) begin
                        w_pc_nxt = w_top;
                        w_sp_nxt = r_sp - SP_W'(1);
                    end else begin
                        w_err_nxt = 1'b1;
                        w_pc_nxt  = w_pc_inc;
                    end
                end else if (opcode == c_op_hlt) begin
                    w_state_nxt = c_s_halt;
                end else if (opcode == c_op_jmp) begin
                    w_pc_nxt = addr_in;
                end else if ((opcode == c_op_skz) && skz_cmp) begin
                    w_pc_nxt = w_pc_inc2;
                end else begin
                    w_pc_nxt = w_pc_inc;
                end
            end
`ifdef PC_BRKPT_EN
            // Breakpoint lets the update land, then freezes on the same edge.
            if (w_update && bp_en && (w_pc_nxt == bp_addr)) begin
                w_state_nxt = c_s_halt;
                w_bp_nxt    = 1'b1;
            end
`endif
        end
    end

    // Output logic
    always_comb begin
        pc_out      = r_pc;
        address_out = fetch_sel ? r_pc : addr_in;
        halted      = (r_state == c_s_halt);
        stack_full  = w_full;
        stack_empty = w_empty;
        stack_err   = r_err;
`ifdef PC_BRKPT_EN
        bp_hit      = r_bp_hit;
`endif
    end

endmodule

`default_nettype wire
